// File: rtl/p32_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : p32_fetch_unit_if
// Description : Instruction-memory and decode-side signals of the p32 fetch
//               stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface p32_fetch_unit_if;
    // instruction memory handshake
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    // decode handshake and redirects
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        update_pc;
    logic [31:0] new_pc;
    logic        exception;
    logic        addr_error;
    logic [31:0] bad_addr;

    modport master (
        output mem_req, mem_addr, dec_valid, dec_inst, dec_pc, addr_error, bad_addr,
        input  mem_ack, mem_rdata, dec_ready, update_pc, new_pc, exception
    );

    modport slave (
        input  mem_req, mem_addr, dec_valid, dec_inst, dec_pc, addr_error, bad_addr,
        output mem_ack, mem_rdata, dec_ready, update_pc, new_pc, exception
    );
endinterface
`default_nettype wire

// File: rtl/p32_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : p32_fetch_unit
// Description : p32 instruction fetch stage: owns the PC, issues one request
//               at a time to instruction memory and presents words to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module p32_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  wire logic            m_clock,
    input  wire logic            p_reset,
    p32_fetch_unit_if.master     bus
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_REQ   = 2'd1,
        ST_DROP  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drop_addr;
    logic [31:0] r_dec_inst;
    logic [31:0] r_dec_pc;
    logic        r_addr_error;
    logic [31:0] r_bad_addr;

    logic        w_redirect;
    logic        w_misaligned;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    assign w_redirect   = bus.exception | bus.update_pc;
    assign w_misaligned = bus.update_pc & ~bus.exception & (bus.new_pc[1:0] != 2'b00);
    assign w_target     = (bus.exception | w_misaligned) ? EXC_VECTOR : bus.new_pc;
    assign w_pc_inc     = r_pc + 32'd4;

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            r_state      <= ST_START;
            r_pc         <= RESET_PC;
            r_drop_addr  <= RESET_PC;
            r_dec_inst   <= 32'd0;
            r_dec_pc     <= 32'd0;
            r_addr_error <= 1'b0;
            r_bad_addr   <= 32'd0;
        end else begin
            r_addr_error <= w_misaligned;
            if (w_misaligned) begin
                r_bad_addr <= bus.new_pc;
            end

            case (r_state)
                ST_START: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                    r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                        if (bus.mem_ack) begin
                            r_state <= ST_REQ;
                        end else begin
                            // the in-flight request must finish at its original address
                            r_drop_addr <= r_pc;
                            r_state     <= ST_DROP;
                        end
                    end else if (bus.mem_ack) begin
                        r_dec_inst <= bus.mem_rdata;
                        r_dec_pc   <= w_pc_inc;
                        r_pc       <= w_pc_inc;
                        r_state    <= ST_HOLD;
                    end
                end
                ST_DROP: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                    if (bus.mem_ack) begin
                        r_state <= ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        r_state <= ST_REQ;
                    end else if (bus.dec_ready) begin
                        r_state <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_START;
                end
            endcase
        end
    end

    assign bus.mem_req    = (r_state == ST_REQ) || (r_state == ST_DROP);
    assign bus.mem_addr   = (r_state == ST_DROP) ? r_drop_addr : r_pc;
    assign bus.dec_valid  = (r_state == ST_HOLD);
    assign bus.dec_inst   = r_dec_inst;
    assign bus.dec_pc     = r_dec_pc;
    assign bus.addr_error = r_addr_error;
    assign bus.bad_addr   = r_bad_addr;

endmodule
`default_nettype wire

// File: tb/tb_p32_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_p32_fetch_unit
// Description : Cycle-by-cycle directed vectors for p32_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_p32_fetch_unit;

    localparam int NV = 23;

    typedef struct packed {
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        upd;
        logic [31:0] npc;
        logic        exc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] dpc;
        logic        aerr;
        logic [31:0] bad;
    } vec_t;

    logic m_clock;
    logic p_reset;
    int   n_checks;
    int   n_errors;
    vec_t vecs [NV];

    p32_fetch_unit_if bus ();

    p32_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0080)
    ) u_dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .bus     (bus.master)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    task automatic check(input string name, input logic req, input logic [31:0] addr,
                         input logic valid, input logic [31:0] inst, input logic [31:0] dpc,
                         input logic aerr, input logic [31:0] bad);
        n_checks++;
        if (bus.mem_req !== req || bus.mem_addr !== addr || bus.dec_valid !== valid ||
            bus.dec_inst !== inst || bus.dec_pc !== dpc || bus.addr_error !== aerr ||
            bus.bad_addr !== bad) begin
            n_errors++;
            $display("FAIL %s: got req=%0b addr=%h valid=%0b inst=%h pc=%h aerr=%0b bad=%h; want req=%0b addr=%h valid=%0b inst=%h pc=%h aerr=%0b bad=%h",
                     name, bus.mem_req, bus.mem_addr, bus.dec_valid, bus.dec_inst, bus.dec_pc,
                     bus.addr_error, bus.bad_addr, req, addr, valid, inst, dpc, aerr, bad);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.mem_ack   = v.ack;
        bus.mem_rdata = v.rdata;
        bus.dec_ready = v.rdy;
        bus.update_pc = v.upd;
        bus.new_pc    = v.npc;
        bus.exception = v.exc;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // fields: ack rdata rdy upd npc exc | req addr valid inst dpc aerr bad
        vecs[0]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,  1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h2001_0005, 1'b1, 1'b0, 32'h0, 1'b0,  1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b0, 32'h4, 1'b1, 32'h2001_0005, 32'h4, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b1, 32'h4, 1'b0, 32'h2001_0005, 32'h4, 1'b0, 32'h0};
        // decode stalls for five cycles
        for (int i = 4; i <= 8; i++)
            vecs[i] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,  1'b0, 32'h8, 1'b1, 32'h0, 32'h8, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b0, 32'h8, 1'b1, 32'h0, 32'h8, 1'b0, 32'h0};
        // redirect while request to 0x8 waits; ack arrives three cycles later
        vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0,  1'b1, 32'h8, 1'b0, 32'h0, 32'h8, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b1, 32'h8, 1'b0, 32'h0, 32'h8, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b1, 32'h8, 1'b0, 32'h0, 32'h8, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0,  1'b1, 32'h8, 1'b0, 32'h0, 32'h8, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0, 1'b0,  1'b1, 32'h100, 1'b0, 32'h0, 32'h8, 1'b0, 32'h0};
        // exception beats update_pc in HOLD
        vecs[15] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b1,  1'b0, 32'h104, 1'b1, 32'h1111_1111, 32'h104, 1'b0, 32'h0};
        vecs[16] = '{1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0, 1'b0,  1'b1, 32'h80, 1'b0, 32'h1111_1111, 32'h104, 1'b0, 32'h0};
        // misaligned redirect from HOLD
        vecs[17] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h102, 1'b0,  1'b0, 32'h84, 1'b1, 32'h2222_2222, 32'h84, 1'b0, 32'h0};
        vecs[18] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,  1'b1, 32'h80, 1'b0, 32'h2222_2222, 32'h84, 1'b1, 32'h102};
        // redirect to top of memory coinciding with an ack (data dropped)
        vecs[19] = '{1'b1, 32'h3333_3333, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0,  1'b1, 32'h80, 1'b0, 32'h2222_2222, 32'h84, 1'b0, 32'h102};
        vecs[20] = '{1'b1, 32'h4444_4444, 1'b1, 1'b0, 32'h0, 1'b0,  1'b1, 32'hFFFF_FFFC, 1'b0, 32'h2222_2222, 32'h84, 1'b0, 32'h102};
        vecs[21] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b0, 32'h0, 1'b1, 32'h4444_4444, 32'h0, 1'b0, 32'h102};
        vecs[22] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,  1'b1, 32'h0, 1'b0, 32'h4444_4444, 32'h0, 1'b0, 32'h102};

        p_reset = 1'b0;
        drive(vecs[0]);
        #2;
        check("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge m_clock);
        @(negedge m_clock);
        p_reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            check($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                  vecs[i].inst, vecs[i].dpc, vecs[i].aerr, vecs[i].bad);
            @(posedge m_clock);
            #1;
        end

        // asynchronous reset while a request to 0x0 is outstanding
        check("req_before_reset", 1'b1, 32'h0, 1'b0, 32'h4444_4444, 32'h0, 1'b0, 32'h102);
        #2;
        p_reset = 1'b0;
        #1;
        check("async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge m_clock);
        p_reset = 1'b1;
        @(posedge m_clock);
        #1;
        check("restart_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/p32_fetch_unit.md
# p32_fetch_unit

Instruction fetch stage of the p32 core. It sits directly upstream of `p32DecodeUnit` and drives the decode unit's `inst`/`pc` inputs and its `decode` strobe. It owns the program counter and runs a single-outstanding-request handshake with instruction memory. It applies redirects from decode (`update_pc`/`pc_out`) and exception redirects, discarding any fetch that is in flight when a redirect arrives.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, address of the first fetch after reset
- `EXC_VECTOR`, 32'h0000_0080, fetch target on `exception` or misaligned redirect

Ports:
- `m_clock`  in  1  clock, all state updates on the rising edge
- `p_reset`  in  1  asynchronous, active-low reset
- `mem_req`  out  1  fetch request; held high until `mem_ack`
- `mem_addr`  out  32  word address of the request; stable while `mem_req`=1
- `mem_ack`  in  1  `mem_rdata` is valid this cycle; the request completes
- `mem_rdata`  in  32  instruction word
- `dec_valid`  out  1  `dec_inst`/`dec_pc` are valid (drives decode's `decode` strobe)
- `dec_ready`  in  1  decode accepts the held instruction this cycle
- `dec_inst`  out  32  fetched instruction
- `dec_pc`  out  32  address of `dec_inst` + 4
- `update_pc`  in  1  redirect request from decode
- `new_pc`  in  32  redirect target (decode `pc_out`)
- `exception`  in  1  redirect to `EXC_VECTOR`; has priority over `update_pc`
- `addr_error`  out  1  one-cycle pulse: redirect target had `new_pc[1:0]` != 0
- `bad_addr`  out  32  misaligned target captured on the last `addr_error`

## Operation
- Registers:
  - `pc` (next fetch address)
  - `state`: START, REQ, DROP, HOLD
  - `dec_inst`, `dec_pc`, `bad_addr`
- Outputs derived from state:
  - `mem_req` = (state==REQ || state==DROP)
  - `mem_addr` = `pc` in REQ; the latched old address in DROP
  - `dec_valid` = (state==HOLD)
- State transitions:
  - START → REQ unconditionally.
  - REQ, `mem_ack`=1, no redirect → HOLD. Latch `dec_inst`=`mem_rdata`, `dec_pc`=`pc`+4, `pc`←`pc`+4.
  - REQ, no ack → stay in REQ.
  - HOLD, `dec_ready`=1 → REQ (instruction consumed).
  - HOLD, `dec_ready`=0 → stay in HOLD; outputs are held stable.
- Redirect (R = `exception` || `update_pc`). Target is `EXC_VECTOR` if `exception`=1, otherwise `new_pc`:
  - In START or HOLD: `pc`←target, next state REQ; the held instruction is discarded.
  - In REQ with `mem_ack`=1: the returned data is discarded, `pc`←target, next state REQ.
  - In REQ with no ack: the old address is latched, `pc`←target, next state DROP.
  - In DROP: a newer redirect overwrites `pc`; on `mem_ack` the data is discarded and the next state is REQ.
- Misaligned target (`update_pc`=1, `exception`=0, `new_pc[1:0]`!=0):
  - `addr_error`=1 in the following cycle and `bad_addr`←`new_pc`.
  - The effective target becomes `EXC_VECTOR`.
- PC arithmetic is modulo 2^32: `pc`=32'hFFFF_FFFC advances to 0, and `dec_pc` wraps the same way.
- No request is ever withdrawn. Once `mem_req` rises, it and the address stay stable until `mem_ack`.

## Timing
- Reset (`p_reset`=0, asynchronous) values:
  - `state`=START, `pc`=`RESET_PC`
  - `mem_req`=0, `mem_addr`=`RESET_PC`
  - `dec_valid`=0, `dec_inst`=0, `dec_pc`=0
  - `addr_error`=0, `bad_addr`=0
- First `mem_req`=1 occurs in the first cycle after the first rising edge following reset release.
- Latency: `mem_ack` in cycle N → `dec_valid`=1 in cycle N+1.
- Throughput: with zero-wait memory and `dec_ready`=1, one instruction every 2 cycles (REQ, HOLD, REQ, ...).
- Handshake: a transfer occurs on an edge where `dec_valid` && `dec_ready`. The same instruction is never presented twice after acceptance.
- Redirect in cycle N → `mem_req` with the new address in cycle N+1, except from REQ without ack, which goes through DROP.
- Reset asserted mid-request: the state is abandoned immediately. Memory must tolerate `mem_req` dropping without an ack.

## Test plan
- Reset release, memory acks every request in its first cycle, `dec_ready`=1, instruction words 0x2001_0005, 0x0000_0000 → `mem_addr` 0x0, 0x4 in cycles 1, 3; `dec_valid` in cycles 2, 4 with `dec_pc` 0x4, 0x8.
- `dec_ready`=0 for 5 cycles while in HOLD → `dec_inst`/`dec_pc` stable, `mem_req`=0; after `dec_ready`=1, next `mem_addr` = previous + 4.
- `update_pc`=1, `new_pc`=0x100 while REQ is waiting (ack delayed 3 cycles) → `mem_addr` holds the old value until ack; that data is never shown on `dec_inst`; next request is to 0x100.
- `exception` and `update_pc` (`new_pc`=0x200) in the same HOLD cycle → next `mem_addr`=0x80; held instruction dropped (`dec_valid`=0 next cycle).
- `update_pc`, `new_pc`=0x102 → `addr_error` pulse of 1 cycle, `bad_addr`=0x102, next fetch at 0x80.
- Redirect to 0xFFFF_FFFC, acked → `dec_pc`=0x0, next `mem_addr`=0x0.
